// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//
// Contents:
//   WORD_BYTES      bytes per instruction word (4)
//   loader_state_t  loader FSM state encoding
//   word_byte_addr  word index -> word-aligned byte address
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  adds the S_CSUM state (trailing XOR checksum byte)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;
`endif

    // Byte address of a word: index * 4, zero-extended to 32 bits.
    function automatic logic [31:0] word_byte_addr(input logic [7:0] idx);
        return {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Assembles a byte stream into 32-bit little-endian words. The first byte of a
// word lands in bits 7:0, the last in bits 31:24.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   clear_i       synchronous clear of byte counter and shift register
//   byte_i        incoming byte
//   byte_valid_i  byte_i is consumed this cycle
//   word_ready_o  high in the cycle the final byte of a word is consumed
//   word_o        assembled word, valid while word_ready_o is high
// -----------------------------------------------------------------------------
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);

    localparam int IDX_W   = $clog2(WORD_BYTES);
    localparam int SHIFT_W = 8 * (WORD_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0]   byte_index_q;
    logic [IDX_W-1:0]   byte_index_d;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_d;

    // The final byte bypasses the shift register so the word is complete in
    // the same cycle it is accepted.
    assign word_ready_o = byte_valid_i & ~clear_i & (byte_index_q == LAST_IDX);
    assign word_o       = {byte_i, shift_q};

    // Next-state for byte counter and shift register.
    always_comb begin
        byte_index_d = byte_index_q;
        shift_d      = shift_q;
        if (clear_i) begin
            byte_index_d = '0;
            shift_d      = '0;
        end else if (byte_valid_i) begin
            shift_d = {byte_i, shift_q[SHIFT_W-1:8]};
            if (byte_index_q == LAST_IDX) begin
                byte_index_d = '0;
            end else begin
                byte_index_d = byte_index_q + IDX_W'(1);
            end
        end else begin
            byte_index_d = byte_index_q;
            shift_d      = shift_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_index_q <= '0;
            shift_q      <= '0;
        end else begin
            byte_index_q <= byte_index_d;
            shift_q      <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot loader: receives a byte stream (word count, then little-endian words,
// optionally a trailing XOR checksum byte) and writes it into instruction
// memory while holding the CPU in reset.
//
// Parameters:
//   IMEM_WORDS  instruction memory depth in 32-bit words (power of two, 2..256)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   rx_data     incoming byte
//   rx_valid    rx_data valid
//   rx_ready    byte accepted when rx_valid & rx_ready at a clk edge
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word-aligned byte address (word_index * 4)
//   imem_wdata  instruction word to write
//   cpu_hold    holds the CPU in reset while high
//   done        image fully loaded
//   error       load aborted (length too large or checksum mismatch)
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  expect one checksum byte (XOR of all data bytes)
//                            after the last word; mismatch ends in S_ERR.
//                            Words already written are not rolled back.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 32
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    // Nine bits so that a depth of 256 is representable in the length check.
    localparam logic [8:0] MAX_WORDS = 9'(IMEM_WORDS);

    loader_state_t state_q;
    loader_state_t state_d;
    logic [7:0]    word_count_q;
    logic [7:0]    word_count_d;
    logic [7:0]    word_index_q;
    logic [7:0]    word_index_d;
    logic          imem_we_q;
    logic          imem_we_d;
    logic [31:0]   imem_addr_q;
    logic [31:0]   imem_addr_d;
    logic [31:0]   imem_wdata_q;
    logic [31:0]   imem_wdata_d;
    logic          rx_ready_q;
    logic          rx_ready_d;
    logic          cpu_hold_q;
    logic          cpu_hold_d;
    logic          done_q;
    logic          done_d;
    logic          error_q;
    logic          error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
    logic [7:0]    csum_d;
`endif

    logic          accept_s;
    logic          pack_valid_s;
    logic          pack_clear_s;
    logic          word_ready_s;
    logic [31:0]   packed_word_s;

    assign accept_s     = rx_valid & rx_ready_q;
    assign pack_valid_s = accept_s & (state_q == S_DATA);
    // Start every image with an empty packer, whatever came before.
    assign pack_clear_s = accept_s & (state_q == S_LEN);

    word_packer u_word_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear_s),
        .byte_i       (rx_data),
        .byte_valid_i (pack_valid_s),
        .word_ready_o (word_ready_s),
        .word_o       (packed_word_s)
    );

    // Next-state and next-output computation for the loader FSM.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        word_index_d = word_index_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_LEN: begin
                if (accept_s) begin
                    if (rx_data == 8'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, rx_data} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d      = S_DATA;
                        word_count_d = rx_data;
                        word_index_d = 8'd0;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (pack_valid_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (word_ready_s) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_byte_addr(word_index_q);
                        imem_wdata_d = packed_word_s;
                        word_index_d = word_index_q + 8'd1;
                        if (word_index_q == word_count_q - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unreachable encoding: fail safe, keep the CPU held.
                state_d = S_ERR;
            end
        endcase

        // Status outputs follow the next state so they are registered.
        rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_d == S_CSUM)
`endif
                     ;
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // Loader FSM state, counters and registered outputs; reset wins over a
    // write completing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LEN;
            word_count_q <= 8'd0;
            word_index_q <= 8'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            rx_ready_q   <= 1'b1;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            word_index_q <= word_index_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            rx_ready_q   <= rx_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter IMEM_WORDS, default 32, giving the instruction memory depth in 32-bit words (power of two, 2..256).
REQ-002 The block SHALL have port clk, input, 1, system clock, sampled on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-004 The block SHALL have port rx_data, input, 8, incoming byte.
REQ-005 The block SHALL have port rx_valid, input, 1, rx_data valid.
REQ-006 The block SHALL have port rx_ready, output, 1, byte accepted when rx_valid & rx_ready at a clk edge.
REQ-007 The block SHALL have port imem_we, output, 1, single-cycle instruction-memory write strobe.
REQ-008 The block SHALL have port imem_addr, output, 32, word-aligned byte address, word_index*4.
REQ-009 The block SHALL have port imem_wdata, output, 32, instruction word to write.
REQ-010 The block SHALL have port cpu_hold, output, 1, holds the CPU in reset while high.
REQ-011 The block SHALL have port done, output, 1, image fully loaded.
REQ-012 The block SHALL have port error, output, 1, load aborted.

Function
REQ-013 The FSM SHALL have states S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR and SHALL enter S_LEN on reset.
REQ-014 In S_LEN the first accepted byte SHALL set word count N: N=0 goes to S_DONE; N>IMEM_WORDS goes to S_ERR; otherwise the FSM goes to S_DATA with word_index=0 and byte_index=0.
REQ-015 In S_DATA the FSM SHALL pack bytes little-endian (first byte into bits 7:0, fourth into bits 31:24).
REQ-016 On acceptance of the fourth byte of a word, imem_we SHALL be high for exactly the next cycle, with imem_addr=word_index*4 and imem_wdata equal to the assembled word; word_index SHALL then increment.
REQ-017 After the write of word N-1 the FSM SHALL go to S_CSUM if the checksum feature is compiled in, otherwise to S_DONE.
REQ-018 rx_ready SHALL equal 1 in S_LEN, S_DATA and S_CSUM, and 0 in S_DONE and S_ERR; back-to-back bytes every cycle SHALL be accepted with no lost data.
REQ-019 cpu_hold SHALL equal 1 in every state except S_DONE.
REQ-020 done SHALL equal 1 only in S_DONE; error SHALL equal 1 only in S_ERR.
REQ-021 S_DONE and S_ERR SHALL be terminal until reset.
REQ-022 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-023 Cycles with rx_valid=0 SHALL stall the FSM with no state change.

Reset
REQ-024 When reset=1, the next clk edge SHALL set the state to S_LEN, all counters and checksum to 0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, cpu_hold=1 and rx_ready=1.
REQ-025 Reset during S_DATA SHALL abandon any partial word and SHALL cancel any pending write in the same cycle.

Configuration
REQ-026 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL maintain a running XOR of all data bytes, and in S_CSUM the next byte SHALL be compared with it: on match go to S_DONE, on mismatch go to S_ERR.
REQ-027 With IMEM_LOADER_CHECKSUM_EN defined, words already written SHALL stay written even when the checksum fails.
REQ-028 Without IMEM_LOADER_CHECKSUM_EN, S_CSUM and the checksum logic SHALL be absent.

Structure
REQ-029 Package imem_loader_pkg SHALL hold the loader_state_t enum and the constant WORD_BYTES=4.
REQ-030 One sub-module, word_packer, SHALL do byte-to-word assembly: byte_index counter, shift register, word_ready pulse.

Verification
REQ-031 Bench SHALL cover: bytes 01 B3 03 53 00 -> one imem_we pulse with addr 0x0 and data 0x005303B3, then done=1, cpu_hold=0 and rx_ready=0.
REQ-032 Bench SHALL cover: N=2 followed by 8 bytes every cycle -> writes at 0x0 and 0x4, exactly 2 pulses.
REQ-033 Bench SHALL cover: N=0x21 with IMEM_WORDS=32 -> error=1, no imem_we, cpu_hold=1.
REQ-034 Bench SHALL cover: N=0 -> done=1 the cycle after acceptance, no writes.
REQ-035 Bench SHALL cover: with IMEM_LOADER_CHECKSUM_EN, N=1, data 01 02 03 04 and checksum 04 -> done; checksum 05 -> error, word still written.
REQ-036 Bench SHALL cover: reset after 2 data bytes, then a fresh 1-word load -> only the new word is written, at addr 0x0.
